// File: rtl/const_stability_monitor.sv
// Watches one sampled bus and locks onto it after THRESHOLD equal valid samples;
// LOCK/BREAK events leave through a one-entry valid/ready port. Optional: CONST_MON_TOGGLE_CNT_EN.
module const_stability_monitor #(
    parameter int WIDTH     = 8,
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = 8,
    localparam int SC_W     = $clog2(THRESHOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample_data,
    input  logic             clear,
    output logic             is_const,
    output logic [WIDTH-1:0] const_value,
    output logic [SC_W-1:0]  stable_cnt,
    output logic             broken,
    output logic             report_valid,
    input  logic             report_ready,
    output logic             report_kind,
    output logic [WIDTH-1:0] report_value,
    output logic             overflow,
    output logic [CNT_W-1:0] toggle_cnt
);

    typedef enum logic [1:0] {EMPTY, TRACK, LOCKED} state_t;

    localparam logic [SC_W-1:0] THR = SC_W'(THRESHOLD);

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] ref_q, ref_nxt;
    logic [SC_W-1:0]  cnt_q, cnt_nxt;
    logic             ev, ev_kind, brk;
    logic [WIDTH-1:0] ev_val;

    always_comb begin
        state_nxt = state_q;
        ref_nxt   = ref_q;
        cnt_nxt   = cnt_q;
        ev        = 1'b0;
        ev_kind   = 1'b0;
        ev_val    = ref_q;
        brk       = 1'b0;
        if (clear) begin
            state_nxt = EMPTY;
            cnt_nxt   = '0;
        end else if (sample_valid) begin
            case (state_q)
                EMPTY: begin
                    ref_nxt = sample_data;
                    cnt_nxt = SC_W'(1);
                    if (THRESHOLD == 1) begin
                        state_nxt = LOCKED;
                        ev        = 1'b1;
                        ev_val    = sample_data;
                    end else begin
                        state_nxt = TRACK;
                    end
                end
                TRACK: begin
                    if (sample_data == ref_q) begin
                        cnt_nxt = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 >= THR) begin
                            cnt_nxt   = THR;
                            state_nxt = LOCKED;
                            ev        = 1'b1;
                            ev_val    = ref_q;
                        end
                    end else begin
                        ref_nxt = sample_data;
                        cnt_nxt = SC_W'(1);
                    end
                end
                LOCKED: begin
                    if (sample_data != ref_q) begin
                        ref_nxt   = sample_data;
                        cnt_nxt   = SC_W'(1);
                        state_nxt = TRACK;
                        brk       = 1'b1;
                        ev        = 1'b1;
                        ev_kind   = 1'b1;
                        ev_val    = sample_data;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            ref_q    <= '0;
            cnt_q    <= '0;
            is_const <= 1'b0;
            broken   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            ref_q    <= ref_nxt;
            cnt_q    <= cnt_nxt;
            is_const <= (state_nxt == LOCKED);
            broken   <= brk;
        end
    end

    // Single-entry report slot: a new event may replace an entry being accepted this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            report_valid <= 1'b0;
            report_kind  <= 1'b0;
            report_value <= '0;
            overflow     <= 1'b0;
        end else if (ev) begin
            if (!report_valid || report_ready) begin
                report_valid <= 1'b1;
                report_kind  <= ev_kind;
                report_value <= ev_val;
            end else begin
                overflow <= 1'b1;
            end
        end else if (report_ready) begin
            report_valid <= 1'b0;
        end
    end

    assign const_value = ref_q;
    assign stable_cnt  = cnt_q;

`ifdef CONST_MON_TOGGLE_CNT_EN
    logic             tog_inc;
    logic [CNT_W-1:0] toggle_q;

    // ref_q always holds the previous valid sample once past EMPTY.
    assign tog_inc = !clear && sample_valid && (state_q != EMPTY) && (sample_data != ref_q);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            toggle_q <= '0;
        end else if (tog_inc && (toggle_q != '1)) begin
            toggle_q <= toggle_q + 1'b1;
        end
    end

    assign toggle_cnt = toggle_q;
`else
    assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_const_stability_monitor.sv
// Directed self-checking bench: THRESHOLD=4 instance for lock/restart/break/clear/reset,
// THRESHOLD=1 instance for immediate lock.
module tb_const_stability_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

`ifdef CONST_MON_TOGGLE_CNT_EN
    localparam int TOG1 = 1;
`else
    localparam int TOG1 = 0;
`endif

    logic       rst = 1'b1;
    logic       a_valid = 1'b0, a_clear = 1'b0, a_ready = 1'b1;
    logic [7:0] a_data = '0;
    logic       a_is_const, a_broken, a_rv, a_rk, a_ovf;
    logic [7:0] a_cv, a_rval, a_tog;
    logic [2:0] a_sc;

    logic       b_valid = 1'b0, b_clear = 1'b0, b_ready = 1'b1;
    logic [7:0] b_data = '0;
    logic       b_is_const, b_broken, b_rv, b_rk, b_ovf;
    logic [7:0] b_cv, b_rval, b_tog;
    logic [0:0] b_sc;

    const_stability_monitor #(.WIDTH(8), .THRESHOLD(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .sample_valid(a_valid), .sample_data(a_data), .clear(a_clear),
        .is_const(a_is_const), .const_value(a_cv), .stable_cnt(a_sc), .broken(a_broken),
        .report_valid(a_rv), .report_ready(a_ready), .report_kind(a_rk), .report_value(a_rval),
        .overflow(a_ovf), .toggle_cnt(a_tog)
    );

    const_stability_monitor #(.WIDTH(8), .THRESHOLD(1), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .sample_valid(b_valid), .sample_data(b_data), .clear(b_clear),
        .is_const(b_is_const), .const_value(b_cv), .stable_cnt(b_sc), .broken(b_broken),
        .report_valid(b_rv), .report_ready(b_ready), .report_kind(b_rk), .report_value(b_rval),
        .overflow(b_ovf), .toggle_cnt(b_tog)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_step(input logic v, input logic [7:0] d);
        a_valid = v;
        a_data  = d;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic a_reset_vals(input string tag);
        chk({tag, "_is_const"}, 32'(a_is_const), 0);
        chk({tag, "_const_value"}, 32'(a_cv), 0);
        chk({tag, "_stable_cnt"}, 32'(a_sc), 0);
        chk({tag, "_broken"}, 32'(a_broken), 0);
        chk({tag, "_report_valid"}, 32'(a_rv), 0);
        chk({tag, "_report_kind"}, 32'(a_rk), 0);
        chk({tag, "_report_value"}, 32'(a_rval), 0);
        chk({tag, "_overflow"}, 32'(a_ovf), 0);
        chk({tag, "_toggle_cnt"}, 32'(a_tog), 0);
    endtask

    task automatic a_clear_pulse();
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
    endtask

    initial begin
        // reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        a_reset_vals("rst");
        chk("b_rst_report_valid", 32'(b_rv), 0);
        chk("b_rst_is_const", 32'(b_is_const), 0);

        // lock at 0x5A after four samples
        a_step(1'b1, 8'h5A);
        chk("lock_cnt1", 32'(a_sc), 1);
        a_step(1'b1, 8'h5A);
        a_step(1'b1, 8'h5A);
        chk("lock_not_yet", 32'(a_is_const), 0);
        chk("lock_no_report_yet", 32'(a_rv), 0);
        a_step(1'b1, 8'h5A);
        chk("lock_is_const", 32'(a_is_const), 1);
        chk("lock_rv", 32'(a_rv), 1);
        chk("lock_kind", 32'(a_rk), 0);
        chk("lock_value", 32'(a_rval), 32'h5A);
        chk("lock_cnt4", 32'(a_sc), 4);
        a_step(1'b1, 8'h5A);
        chk("locked_hold_cnt", 32'(a_sc), 4);
        chk("locked_accepted", 32'(a_rv), 0);
        chk("locked_no_break", 32'(a_broken), 0);

        // restart during TRACK
        a_clear_pulse();
        chk("clr_cnt", 32'(a_sc), 0);
        chk("clr_is_const", 32'(a_is_const), 0);
        a_step(1'b1, 8'h5A);
        a_step(1'b1, 8'h5A);
        chk("rs_cnt2", 32'(a_sc), 2);
        a_step(1'b1, 8'h11);
        chk("rs_cnt_restart", 32'(a_sc), 1);
        chk("rs_ref", 32'(a_cv), 32'h11);
        a_step(1'b1, 8'h11);
        a_step(1'b1, 8'h11);
        chk("rs_not_locked", 32'(a_is_const), 0);
        a_step(1'b1, 8'h11);
        chk("rs_locked", 32'(a_is_const), 1);
        chk("rs_rv", 32'(a_rv), 1);
        chk("rs_value", 32'(a_rval), 32'h11);
        chk("rs_toggle", 32'(a_tog), TOG1);

        // break with backpressure
        a_clear_pulse();
        a_ready = 1'b0;
        repeat (4) a_step(1'b1, 8'h00);
        chk("bp_locked", 32'(a_is_const), 1);
        chk("bp_lock_value", 32'(a_rval), 32'h00);
        chk("bp_rv", 32'(a_rv), 1);
        a_step(1'b1, 8'h01);
        chk("bp_broken", 32'(a_broken), 1);
        chk("bp_unlocked", 32'(a_is_const), 0);
        chk("bp_overflow", 32'(a_ovf), 1);
        chk("bp_kind_held", 32'(a_rk), 0);
        chk("bp_value_held", 32'(a_rval), 32'h00);
        chk("bp_ref", 32'(a_cv), 32'h01);
        chk("bp_cnt", 32'(a_sc), 1);
        chk("bp_toggle", 32'(a_tog), TOG1);
        a_step(1'b0, 8'h00);
        chk("bp_broken_one_cycle", 32'(a_broken), 0);
        chk("bp_rv_stable", 32'(a_rv), 1);
        a_ready = 1'b1;
        tick();
        chk("bp_accepted", 32'(a_rv), 0);
        chk("bp_overflow_sticky", 32'(a_ovf), 1);

        // gaps and clear
        a_clear_pulse();
        chk("clr_keeps_overflow", 32'(a_ovf), 1);
        a_step(1'b1, 8'h33);
        a_step(1'b0, 8'h00);
        a_step(1'b1, 8'h33);
        a_step(1'b0, 8'h00);
        a_step(1'b1, 8'h33);
        a_step(1'b0, 8'h00);
        chk("gap_cnt3", 32'(a_sc), 3);
        chk("gap_not_locked", 32'(a_is_const), 0);
        a_step(1'b1, 8'h33);
        chk("gap_locked", 32'(a_is_const), 1);
        chk("gap_value", 32'(a_rval), 32'h33);
        a_clear_pulse();
        a_step(1'b1, 8'h77);
        a_step(1'b1, 8'h77);
        a_clear = 1'b1;
        a_step(1'b1, 8'h77);
        a_clear = 1'b0;
        chk("clr_wins_cnt", 32'(a_sc), 0);
        chk("clr_wins_const", 32'(a_is_const), 0);
        chk("clr_no_event", 32'(a_rv), 0);
        repeat (3) a_step(1'b1, 8'h77);
        chk("fresh_cnt3", 32'(a_sc), 3);
        chk("fresh_not_locked", 32'(a_is_const), 0);
        a_step(1'b1, 8'h77);
        chk("fresh_locked", 32'(a_is_const), 1);
        chk("fresh_value", 32'(a_rval), 32'h77);

        // THRESHOLD=1 instance
        b_valid = 1'b1;
        b_data  = 8'hA5;
        tick();
        b_valid = 1'b0;
        chk("t1_is_const", 32'(b_is_const), 1);
        chk("t1_rv", 32'(b_rv), 1);
        chk("t1_kind", 32'(b_rk), 0);
        chk("t1_value", 32'(b_rval), 32'hA5);
        chk("t1_cnt", 32'(b_sc), 1);
        b_valid = 1'b1;
        b_data  = 8'h5B;
        tick();
        b_valid = 1'b0;
        chk("t1_broken", 32'(b_broken), 1);
        chk("t1_break_kind", 32'(b_rk), 1);
        chk("t1_break_value", 32'(b_rval), 32'h5B);
        chk("t1_break_rv", 32'(b_rv), 1);

        // reset while locked with a pending report
        a_clear_pulse();
        a_ready = 1'b0;
        repeat (4) a_step(1'b1, 8'hC3);
        chk("mid_locked", 32'(a_is_const), 1);
        chk("mid_pending", 32'(a_rv), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_ready = 1'b1;
        a_reset_vals("mid_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
